multu_hilo: RTL and testbench

Sequential 32x32 unsigned multiplier with HI/LO result registers, in the execute stage beside the ripple-carry ALU. It takes the same operand buses (`dataA`, `dataB`) and funct code (`Signal`) as the ALU. It forms the 64-bit product by iterative shift-and-add. `MFHI`/`MFLO` read the result out on `dataOut`, which feeds the execute-stage result mux downstream of both units.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/multu_hilo_if.sv | 24 ++
 rtl/multu_datapath.sv | 38 +++
 rtl/multu_hilo.sv | 99 +++++++++
 tb/tb_multu_hilo.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Execute-stage constants shared by the ALU and the HI/LO multiplier:
// funct codes and the multiplier FSM state encoding.
package alu_pkg;

  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

  function automatic logic is_multu(input logic [5:0] funct);
    return funct == FUNCT_MULTU;
  endfunction

endpackage

// File: rtl/multu_hilo_if.sv
// Request/response bundle between the execute stage and the HI/LO multiplier.
interface multu_hilo_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dataOut;

  modport master (
    output start, dataA, dataB, Signal,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, dataA, dataB, Signal,
    output busy, done, dataOut
  );

endinterface

// File: rtl/multu_datapath.sv
// Shift-and-add core: multiplicand register, 2W-bit product register and
// the W+1-bit adder whose carry becomes the top bit of the shifted product.
module multu_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] prod_next
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;

  // prod_next is the product after the current step, so the controller can
  // commit HI/LO on the same edge as the final iteration.
  always_comb begin
    sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};
    prod_next = {sum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand <= '0;
      prod  <= '0;
    end else if (load) begin
      mcand <= mcand_in;
      prod  <= {{WIDTH{1'b0}}, mplier_in};
    end else if (step) begin
      prod  <= prod_next;
    end
  end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned multiplier with HI/LO result registers; MULTU starts a
// W-cycle run, MFHI/MFLO read the last committed result on dataOut.
module multu_hilo
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          reset,
  multu_hilo_if.slave  bus
);

  mult_state_t        state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] prod_next;
  logic               accept;
  logic               last_step;

  // Starts during RUN are dropped; a start in the DONE cycle is taken.
  assign accept    = bus.start && is_multu(bus.Signal) && (state != ST_RUN);
  assign last_step = (count == CNT_W'(WIDTH - 1));

  multu_datapath #(
    .WIDTH (WIDTH)
  ) datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (state == ST_RUN),
    .mcand_in  (bus.dataA),
    .mplier_in (bus.dataB),
    .prod_next (prod_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state  <= ST_RUN;
            busy_q <= 1'b1;
            count  <= '0;
          end
        end
        ST_RUN: begin
          count <= count + CNT_W'(1);
          if (last_step) begin
            hi     <= prod_next[2*WIDTH-1:WIDTH];
            lo     <= prod_next[WIDTH-1:0];
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state  <= ST_RUN;
            busy_q <= 1'b1;
            count  <= '0;
          end else begin
            state  <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_comb begin
    bus.dataOut = '0;
    if (bus.Signal == FUNCT_MFHI) begin
      bus.dataOut = hi;
    end else if (bus.Signal == FUNCT_MFLO) begin
      bus.dataOut = lo;
    end
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Bench for multu_hilo: directed MULTU vectors feed a scoreboard queue that a
// monitor drains on every done pulse; HI/LO are also read back via MFHI/MFLO.
module tb_multu_hilo;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] lo;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  int   cycle;
  int   checks;
  int   errors;
  exp_t sb[$];

  multu_hilo_if #(.WIDTH(32)) bus ();

  multu_hilo #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    bus.start  = st;
    bus.Signal = sig;
    bus.dataA  = a;
    bus.dataB  = b;
  endtask

  // Every done pulse must match the oldest outstanding request in LO and timing.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (bus.done === 1'b1) begin
          checkOutput("done_width", {31'b0, prev_done}, 32'd0);
          checkOutput("busy_at_done", {31'b0, bus.busy}, 32'd0);
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("done_latency", cycle, e.due);
            checkOutput("lo_at_done", bus.dataOut, e.lo);
          end
        end
        prev_done = bus.done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic readHiLo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    applyStimulus(1'b0, FUNCT_MFHI, 32'd0, 32'd0);
    #1 checkOutput({tag, "_hi"}, bus.dataOut, exp_hi);
    applyStimulus(1'b0, FUNCT_MFLO, 32'd0, 32'd0);
    #1 checkOutput({tag, "_lo"}, bus.dataOut, exp_lo);
  endtask

  task automatic issueMult(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_lo);
    exp_t e;
    applyStimulus(1'b1, FUNCT_MULTU, a, b);
    e.lo  = exp_lo;
    e.due = cycle + 33;
    sb.push_back(e);
    @(negedge clk);
    applyStimulus(1'b0, FUNCT_MFLO, 32'd0, 32'd0);
    checkOutput("busy_after_accept", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic runMult(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_lo);
    @(negedge clk);
    issueMult(a, b, exp_lo);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no done, expected done within 40 cycles", name);
    end
  endtask

  initial begin
    logic [5:0] codes [8];
    int         seen;
    codes = '{FUNCT_MULTU, FUNCT_MFHI, FUNCT_MFLO, FUNCT_ADD,
              FUNCT_AND, FUNCT_OR, FUNCT_SUB, FUNCT_SLT};
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    applyStimulus(1'b0, FUNCT_MFLO, 32'd0, 32'd0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, codes[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      #1;
      checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
      checkOutput("reset_dataout", bus.dataOut, 32'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, FUNCT_MFLO, 32'd0, 32'd0);
    reset = 1'b1;
    readHiLo("post_reset", 32'd0, 32'd0);

    runMult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    waitDone("done_ffff");
    readHiLo("ffff", 32'hFFFF_FFFE, 32'h0000_0001);

    runMult(32'h1234_5678, 32'h0, 32'h0);
    waitDone("done_zero");
    readHiLo("times_zero", 32'h0, 32'h0);

    runMult(32'h0001_0000, 32'h0001_0000, 32'h0);
    waitDone("done_2p32");
    readHiLo("two_pow_32", 32'h1, 32'h0);

    // 3 x 5 with a stray MULTU 7 x 7 sampled on the fifth edge of the run
    runMult(32'd3, 32'd5, 32'h0000_000F);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, FUNCT_MULTU, 32'd7, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, FUNCT_MFLO, 32'd0, 32'd0);
    #1 checkOutput("midrun_lo", bus.dataOut, 32'h0);
    checkOutput("midrun_busy", {31'b0, bus.busy}, 32'd1);
    applyStimulus(1'b0, FUNCT_MFHI, 32'd0, 32'd0);
    #1 checkOutput("midrun_hi", bus.dataOut, 32'h1);
    applyStimulus(1'b0, FUNCT_MFLO, 32'd0, 32'd0);
    waitDone("done_3x5");
    readHiLo("three_x_five", 32'h0, 32'h0000_000F);

    // Abort a run with reset after ten iterations
    runMult(32'hDEAD_BEEF, 32'd2, 32'hBD5B_7DDE);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("abort_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checkOutput("abort_no_done", seen, 32'd0);
    readHiLo("after_abort", 32'h0, 32'h0);
    runMult(32'hDEAD_BEEF, 32'd2, 32'hBD5B_7DDE);
    waitDone("done_rerun");
    readHiLo("rerun", 32'h1, 32'hBD5B_7DDE);

    // Non-multiply funct with start must not touch the unit
    @(negedge clk);
    applyStimulus(1'b1, FUNCT_ADD, 32'd9, 32'd9);
    @(negedge clk);
    applyStimulus(1'b0, FUNCT_MFLO, 32'd0, 32'd0);
    checkOutput("add_no_busy", {31'b0, bus.busy}, 32'd0);
    readHiLo("after_add", 32'h1, 32'hBD5B_7DDE);

    // MULTU presented in the DONE cycle is accepted immediately
    runMult(32'd3, 32'd5, 32'h0000_000F);
    waitDone("done_before_b2b");
    issueMult(32'h0001_0000, 32'h0001_0000, 32'h0);
    waitDone("done_b2b");
    readHiLo("b2b", 32'h1, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
